// File: rtl/return_address_stack_pkg.sv
// Shared RISC-V link-register constants and the per-edge operation
// encoding used by the return-address stack.
package return_address_stack_pkg;

   localparam logic [31:0] RA_LINK_OFFSET = 32'd4;
   localparam logic [4:0]  REG_RA         = 5'd1;
   localparam logic [4:0]  REG_T0         = 5'd5;

   typedef enum logic [2:0] {
      RAS_IDLE,
      RAS_FLUSH,
      RAS_REPLACE,
      RAS_PUSH,
      RAS_POP
   } ras_op_e;

   // Priority: flush > call-that-returns > push > pop; a combined
   // push/pop on an empty stack degrades to a plain push.
   function automatic ras_op_e ras_decode(input logic push, input logic pop,
                                          input logic flush, input logic nonempty);
      ras_op_e op;
      op = RAS_IDLE;
      if (flush)                      op = RAS_FLUSH;
      else if (push && pop && nonempty) op = RAS_REPLACE;
      else if (push)                  op = RAS_PUSH;
      else if (pop)                   op = RAS_POP;
      return op;
   endfunction

endpackage

// File: rtl/return_address_stack_storage.sv
// Depth x NBits entry array: one synchronous write port, one
// asynchronous read port, all entries cleared by reset.
module ras_storage #(
   parameter int unsigned NBits = 32,
   parameter int unsigned Depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [NBits-1:0]         wdata_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [NBits-1:0]         rdata_o
);

   logic [NBits-1:0] mem_q [Depth];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack: stores call PC + 4 on retired calls and replays
// the most recent link value as the predicted return target.
module return_address_stack
   import return_address_stack_pkg::*;
#(
   parameter int unsigned NBits = 32,
   parameter int unsigned Depth = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [NBits-1:0]           call_pc_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [NBits-1:0]           top_o,
   output logic                       valid_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]  tp_q, tp_d, tp_m1;
   logic [CntW-1:0]  count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             we;
   logic [PtrW-1:0]  waddr;
   logic [NBits-1:0] wdata, rdata;
   logic             nonempty;
   ras_op_e          op;

   assign nonempty = (count_q != '0);
   assign tp_m1    = tp_q - PtrW'(1);
   assign wdata    = call_pc_i + NBits'(RA_LINK_OFFSET);
   assign op       = ras_decode(push_i, pop_i, flush_i, nonempty);

   always_comb begin
      tp_d    = tp_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      we      = 1'b0;
      waddr   = tp_q;
      case (op)
         RAS_FLUSH: begin
            tp_d    = '0;
            count_d = '0;
         end
         RAS_REPLACE: begin
            we    = 1'b1;
            waddr = tp_m1;
         end
         RAS_PUSH: begin
            // A full stack keeps writing at tp; wrap-around drops the oldest.
            we   = 1'b1;
            tp_d = tp_q + PtrW'(1);
            if (count_q == CntW'(Depth)) ovf_d   = 1'b1;
            else                         count_d = count_q + CntW'(1);
         end
         RAS_POP: begin
            if (nonempty) begin
               tp_d    = tp_m1;
               count_d = count_q - CntW'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tp_q    <= tp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   ras_storage #(
      .NBits (NBits),
      .Depth (Depth)
   ) u_storage (
      .clk     (clk),
      .reset   (reset),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (tp_m1),
      .rdata_o (rdata)
   );

   assign top_o       = nonempty ? rdata : '0;
   assign valid_o     = nonempty;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Randomized bench for return_address_stack against a queue-based LIFO model.
module tb_return_address_stack;

   localparam int NB = 32;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push_i = 1'b0, pop_i = 1'b0, flush_i = 1'b0;
   logic [NB-1:0] call_pc_i = '0;
   logic [NB-1:0] top_o;
   logic          valid_o, overflow_o, underflow_o;
   logic [3:0]    count_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_q[$];
   bit          exp_ovf = 0, exp_unf = 0;

   return_address_stack #(.NBits(NB), .Depth(DP)) dut (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_i),
      .call_pc_i   (call_pc_i),
      .pop_i       (pop_i),
      .flush_i     (flush_i),
      .top_o       (top_o),
      .valid_o     (valid_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Stack semantics as a bounded LIFO list of link values.
   task automatic model_step(input bit ps, input bit pp, input bit fl, input logic [31:0] pc);
      logic [31:0] link;
      link    = pc + 32'd4;
      exp_ovf = 0;
      exp_unf = 0;
      if (fl) ref_q.delete();
      else if (ps && pp && ref_q.size() > 0) ref_q[ref_q.size()-1] = link;
      else if (ps) begin
         ref_q.push_back(link);
         if (ref_q.size() > DP) begin
            void'(ref_q.pop_front());
            exp_ovf = 1;
         end
      end else if (pp) begin
         if (ref_q.size() > 0) void'(ref_q.pop_back());
         else exp_unf = 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] et;
      et = (ref_q.size() > 0) ? ref_q[ref_q.size()-1] : 32'd0;
      check_eq({tag, ".top"},   top_o,       et);
      check_eq({tag, ".valid"}, valid_o,     ref_q.size() > 0);
      check_eq({tag, ".count"}, count_o,     ref_q.size());
      check_eq({tag, ".ovf"},   overflow_o,  exp_ovf);
      check_eq({tag, ".unf"},   underflow_o, exp_unf);
   endtask

   task automatic do_cycle(input string tag, input bit ps, input bit pp, input bit fl,
                           input logic [31:0] pc);
      push_i    = ps;
      pop_i     = pp;
      flush_i   = fl;
      call_pc_i = pc;
      @(posedge clk);
      model_step(ps, pp, fl, pc);
      #1;
      push_i  = 0;
      pop_i   = 0;
      flush_i = 0;
      check_outputs(tag);
   endtask

   initial begin
      int r;
      logic [31:0] pc;

      #12;
      check_outputs("reset");
      reset = 1'b1;

      do_cycle("push1", 1, 0, 0, 32'h0040_0010);
      check_eq("push1.const", top_o, 32'h0040_0014);
      do_cycle("fl0", 0, 0, 1, 0);

      do_cycle("pA", 1, 0, 0, 32'h100);
      do_cycle("pB", 1, 0, 0, 32'h200);
      do_cycle("pC", 1, 0, 0, 32'h300);
      check_eq("pC.const", top_o, 32'h304);
      do_cycle("pop1", 0, 1, 0, 0);
      check_eq("pop1.const", top_o, 32'h204);
      do_cycle("pop2", 0, 1, 0, 0);
      check_eq("pop2.const", top_o, 32'h104);
      do_cycle("pop3", 0, 1, 0, 0);
      do_cycle("pop4", 0, 1, 0, 0);
      check_eq("pop4.unf", underflow_o, 1'b1);
      do_cycle("idle", 0, 0, 0, 0);

      for (int k = 0; k < 9; k++) do_cycle("ovfpush", 1, 0, 0, 32'h1000 + 32'(4*k));
      check_eq("ovf.const", overflow_o, 1'b1);
      check_eq("ovf.count", count_o, 4'd8);
      for (int k = 0; k < 8; k++) do_cycle("ovfpop", 0, 1, 0, 0);
      check_eq("ovfpop.empty", valid_o, 1'b0);

      do_cycle("p504", 1, 0, 0, 32'h500);
      do_cycle("repl", 1, 1, 0, 32'h700);
      check_eq("repl.const", top_o, 32'h704);
      do_cycle("fl1", 0, 0, 1, 0);
      do_cycle("wrap", 1, 0, 0, 32'hFFFF_FFFC);
      check_eq("wrap.const", top_o, 32'h0);
      check_eq("wrap.valid", valid_o, 1'b1);

      do_cycle("f3a", 1, 0, 0, 32'h10);
      do_cycle("f3b", 1, 0, 0, 32'h20);
      do_cycle("flpush", 1, 0, 1, 32'h30);
      check_eq("flpush.count", count_o, 4'd0);

      do_cycle("r1", 1, 0, 0, 32'h40);
      do_cycle("r2", 1, 0, 0, 32'h50);
      #2 reset = 1'b0;
      #1;
      ref_q.delete();
      exp_ovf = 0;
      exp_unf = 0;
      check_outputs("asyncrst");
      #1 reset = 1'b1;
      do_cycle("rstpop", 0, 1, 0, 0);
      check_eq("rstpop.unf", underflow_o, 1'b1);

      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(99);
         pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         if (r < 3)       do_cycle("rnd.flush", 0, 0, 1, pc);
         else if (r < 13) do_cycle("rnd.both", 1, 1, 0, pc);
         else if (r < 53) do_cycle("rnd.push", 1, 0, 0, pc);
         else if (r < 93) do_cycle("rnd.pop", 0, 1, 0, pc);
         else             do_cycle("rnd.idle", 0, 0, 0, pc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
